// File: rtl/conv_pkg.sv
// Shared pixel/window types for the window generator and the downstream convolution stage.
package conv_pkg;

    localparam int PIX_W  = 30;
    localparam int CH_W   = 10;
    localparam int CONV_K = 3;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [CH_W-1:0]  channel_t;

    // Window indexed [row][col]; row 0 is the oldest line, col 0 the leftmost tap.
    typedef pixel_t [CONV_K-1:0][CONV_K-1:0] window_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } conv_state_e;

    function automatic channel_t getRed(input pixel_t p);
        return p[3*CH_W-1:2*CH_W];
    endfunction

    function automatic channel_t getGreen(input pixel_t p);
        return p[2*CH_W-1:CH_W];
    endfunction

    function automatic channel_t getBlue(input pixel_t p);
        return p[CH_W-1:0];
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image line of pixel storage; the read returns the value held before this cycle's write.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH  = 640,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  pixel_t            wrData_i,
    output pixel_t            rdData_o
);

    pixel_t mem [DEPTH];

    assign rdData_o = mem[addr_i];

    always_ff @(posedge clock) begin
        if (wrEn_i) begin
            mem[addr_i] <= wrData_i;
        end
    end

endmodule

// File: rtl/conv_window_buffer.sv
// Streaming KxK window generator over raster-order pixels.
// Define CONV_WINDOW_BORDER_EN to emit a zero-padded window for every pixel instead of interior ones only.
module conv_window_buffer
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic                                      in_sof,
    input  pixel_t                                    in_pixel,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output pixel_t [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] out_window,
    output logic [$clog2(HEIGHT)-1:0]                 out_row,
    output logic [$clog2(WIDTH)-1:0]                  out_col,
    output logic                                      out_last
);

    localparam int K     = KERNEL_SIZE;
    localparam int ROW_W = $clog2(HEIGHT);
    localparam int COL_W = $clog2(WIDTH);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);

    conv_state_e              state_q, state_d;
    logic [ROW_W-1:0]         rowCnt_q, rowCnt_d;
    logic [COL_W-1:0]         colCnt_q, colCnt_d;
    logic                     valid_q, valid_d;
    logic [ROW_W-1:0]         outRow_q, outRow_d;
    logic [COL_W-1:0]         outCol_q, outCol_d;
    logic                     last_q, last_d;
    pixel_t [K-1:0][K-1:0]    win_q, win_d, winShift;
    pixel_t [K-1:0]           newCol;
    pixel_t                   lbWr [K-1];
    pixel_t                   lbRd [K-1];

    logic             accept;
    logic             process;
    logic             isLast;
    logic             emit;
    logic [ROW_W-1:0] beatRow;
    logic [COL_W-1:0] beatCol;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign process  = accept && (in_sof || (state_q == STREAM));
    assign beatRow  = in_sof ? '0 : rowCnt_q;
    assign beatCol  = in_sof ? '0 : colCnt_q;
    assign isLast   = (beatRow == LAST_ROW) && (beatCol == LAST_COL);

    // Each line buffer hands its old contents to the next, so buffer j holds line r-1-j.
    assign lbWr[0] = in_pixel;
    for (genvar j = 1; j < K - 1; j++) begin : gChain
        assign lbWr[j] = lbRd[j-1];
    end

    for (genvar j = 0; j < K - 1; j++) begin : gLine
        conv_line_buffer #(
            .DEPTH (WIDTH),
            .ADDR_W(COL_W)
        ) uLine (
            .clock   (clock),
            .wrEn_i  (process),
            .addr_i  (beatCol),
            .wrData_i(lbWr[j]),
            .rdData_o(lbRd[j])
        );
    end

    always_comb begin
        newCol[K-1] = in_pixel;
        for (int j = 0; j < K - 1; j++) begin
            newCol[K-2-j] = lbRd[j];
        end
    end

    // Shift left by one column, then blank taps above row 0 or left of column 0 (stale lines, previous-line wrap).
    always_comb begin
        winShift = win_q;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                winShift[r][c] = win_q[r][c+1];
            end
            winShift[r][K-1] = newCol[r];
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if ((int'(beatRow) + r < K - 1) || (int'(beatCol) + c < K - 1)) begin
                    winShift[r][c] = '0;
                end
            end
        end
    end

    always_comb begin
`ifdef CONV_WINDOW_BORDER_EN
        emit = 1'b1;
`else
        emit = (int'(beatRow) >= K - 1) && (int'(beatCol) >= K - 1);
`endif
    end

    always_comb begin
        state_d  = state_q;
        rowCnt_d = rowCnt_q;
        colCnt_d = colCnt_q;
        valid_d  = valid_q;
        outRow_d = outRow_q;
        outCol_d = outCol_q;
        last_d   = last_q;
        win_d    = win_q;
        if (process) begin
            state_d  = isLast ? IDLE : STREAM;
            win_d    = winShift;
            outRow_d = beatRow;
            outCol_d = beatCol;
            last_d   = isLast;
            valid_d  = emit;
            if (isLast) begin
                rowCnt_d = '0;
                colCnt_d = '0;
            end else if (beatCol == LAST_COL) begin
                rowCnt_d = beatRow + ROW_W'(1);
                colCnt_d = '0;
            end else begin
                rowCnt_d = beatRow;
                colCnt_d = beatCol + COL_W'(1);
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rowCnt_q <= '0;
            colCnt_q <= '0;
            valid_q  <= 1'b0;
            outRow_q <= '0;
            outCol_q <= '0;
            last_q   <= 1'b0;
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            rowCnt_q <= rowCnt_d;
            colCnt_q <= colCnt_d;
            valid_q  <= valid_d;
            outRow_q <= outRow_d;
            outCol_q <= outCol_d;
            last_q   <= last_d;
            win_q    <= win_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_window = win_q;
    assign out_row    = outRow_q;
    assign out_col    = outCol_q;
    assign out_last   = last_q;

endmodule

// File: doc/conv_window_buffer.md
# conv_window_buffer

Streaming window generator directly upstream of the kernel convolution stage. Accepts one raster-order RGB pixel per cycle (10 bits per channel, 30 bits packed), buffers the last KERNEL_SIZE-1 image lines, and presents a KERNEL_SIZE x KERNEL_SIZE pixel window per accepted pixel. The convolution stage multiplies this window by its kernel, so it no longer needs the whole frame in parallel.

## Interface
- KERNEL_SIZE, 3, window edge length; odd, ≥3
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- PIX_W, 30, packed pixel width {R[29:20], G[19:10], B[9:0]}
- clock  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  input pixel valid
- in_ready  out  1  input accept; handshake completes when in_valid & in_ready
- in_sof  in  1  start of frame; qualifies the pixel at (0,0)
- in_pixel  in  PIX_W  input pixel
- out_valid  out  1  window valid
- out_ready  in  1  downstream accept
- out_window  out  [KERNEL_SIZE][KERNEL_SIZE][PIX_W]  [r][c]; r=0 top (oldest) line, c=0 leftmost; [K-1][K-1] = newest pixel
- out_row  out  $clog2(HEIGHT)  row of newest pixel
- out_col  out  $clog2(WIDTH)  column of newest pixel
- out_last  out  1  window contains final pixel (HEIGHT-1, WIDTH-1)

## Operation
- States: IDLE (waiting for frame), STREAM. Reset enters IDLE.
- IDLE: in_ready=1. Beats without in_sof are accepted and discarded, with no output. A beat with in_sof is taken as (0,0) and moves to STREAM.
- STREAM: each accepted beat writes the pixel into the line buffers and shifts it into the KxK window register. The column counter increments. When the column counter reaches WIDTH-1, it wraps to 0 and the row counter increments.
- Final pixel (HEIGHT-1, WIDTH-1): its window carries out_last=1, then the block returns to IDLE.
- in_sof during STREAM resynchronises the frame: the beat is treated as (0,0), the counters restart, and old buffer contents are treated as off-image.
- Emission is defined by the configuration macro below.
- Off-image taps: any tap at row < 0 or col < 0 relative to the newest pixel is forced to 0. Pixels from the previous line never wrap in as left-column taps.
- Pixel data is passed through unmodified. There is no arithmetic on channels.

## Timing
- Latency: the window for a beat accepted in cycle N is valid in cycle N+1 (registered output).
- in_ready = !out_valid | out_ready (combinational). A single output register provides back-pressure with no bubbles at full rate.
- While out_valid=1 and out_ready=0: out_window, out_row, out_col and out_last hold stable, and no input is accepted.
- If a beat produces no window (suppressed or dropped), out_valid deasserts in the next cycle once the current window is taken.
- Reset values: out_valid=0, out_window=all 0, out_row=0, out_col=0, out_last=0, state=IDLE. in_ready=1 after reset.
- Reset asserted mid-frame aborts immediately. The next frame requires a new in_sof.
- Line-buffer read and write use the same address (the column counter) in the same cycle, read-before-write. The result is one read and one write per buffer per cycle.

## Configuration
- Macro CONV_WINDOW_BORDER_EN.
- Defined: every accepted STREAM pixel emits a window, WIDTH*HEIGHT windows per frame, with off-image taps zeroed.
- Undefined: a window is emitted only when out_row ≥ K-1 and out_col ≥ K-1, giving (WIDTH-K+1)*(HEIGHT-K+1) windows per frame. Other beats update state but leave out_valid low. out_last behaviour is identical in both modes.

## Structure
- Package conv_pkg: pixel_t (logic [PIX_W-1:0]), channel width constant CH_W=10, and the window array typedef. The downstream convolution stage shares this package.
- Sub-module conv_line_buffer: one WIDTH-deep x PIX_W RAM line with read-before-write. KERNEL_SIZE-1 instances are chained, each feeding the next.

## Test plan
- Use WIDTH=4, HEIGHT=3, K=3, pixel = 0x100 + row*16 + col for all scenarios.
- Border off, out_ready=1: exactly 2 windows. The first (out_row=2, out_col=2) has [0][0]=0x100 and [2][2]=0x122. The second has out_col=3 and out_last=1.
- Border on: the first window has [2][2]=0x100 and all other taps 0. There are 12 windows in total. The window at (1,0) has column 0 and column 1 all 0, with [1][2]=0x100 and [2][2]=0x110.
- out_ready held low 5 cycles while a window is valid: in_ready=0, and out_window and out_row/out_col are unchanged. Release gives the next window 1 cycle after its beat is accepted.
- in_sof reasserted at (1,2): the counters restart. Border off, the next window appears only at the new (2,2), with [0][0] = the new frame's (0,0).
- In IDLE, 3 beats without in_sof are dropped: no out_valid, in_ready=1. Then reset mid-frame gives out_valid=0, out_window=0, and a frame restarted with in_sof produces correct windows.
